booth_seq_ctrl: RTL and testbench
=================================

# booth_seq_ctrl

Sequencing controller for the shared 2N+1-bit shift register used as the Booth multiplier datapath. The register holds the packed word {A, Q, Q-1}. The controller accepts a signed N×N multiply request, drives the register's load and op-select lines through initialise / add-subtract / arithmetic-shift steps, and returns the 2N-bit signed product with a fixed latency. It sits between the top-level operand source and the register, and is the only master of the register while busy.

## Interface
- N, 8, operand width; the register width is 2N+1 (17 at default).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mcand  in  N  signed multiplicand (M), captured when start is accepted.
- mplier  in  N  signed multiplier, captured when start is accepted.
- reg_out  in  2N+1  current register contents {A[2N:N+1], Q[N:1], Q-1[0]}.
- reg_in  out  2N+1  parallel-load data to the register; 0 when not loading.
- reg_load  out  1  register write enable.
- reg_sel  out  3  register op: 3'd1 parallel load, 3'd5 arithmetic shift right by 1; 3'd0 when idle or holding.
- busy  out  1  high from INIT through the final SHIFT.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; high for an unsupported operand.
- product  out  2N  reg_out[2N:1], continuous; valid from done until the next accepted start.

## Operation
- Register contract:
  - reg_load=0: hold.
  - reg_load=1, sel=1: load reg_in.
  - reg_load=1, sel=5: ASR of all 2N+1 bits, MSB replicated.
  - The result is visible on reg_out the cycle after the edge.
- States: IDLE, INIT, EVAL, SHIFT, DONE.
- IDLE → INIT on start=1. Captures M and mplier. An iteration count register is cleared.
- INIT:
  - Normal case: load {N'b0, mplier, 1'b0} → EVAL.
  - If mcand == −2^(N−1) (8'h80): load all-zeros → DONE with err=1. The algorithm would overflow −M in N bits.
- EVAL: inspect reg_out[1:0].
  - 2'b01: load {A+M, Q, Q-1}.
  - 2'b10: load {A−M, Q, Q-1}.
  - 00 or 11: hold (reg_load=0).
  - Always exactly one cycle, then → SHIFT.
- SHIFT: reg_load=1, reg_sel=5; count += 1. Next state is DONE if the count reaches N, else EVAL.
- DONE: done=1 for one cycle; err as determined in INIT, 0 otherwise → IDLE.
- Arithmetic: A±M is N-bit two's-complement and wraps; the carry is discarded. The product is the exact signed 2N-bit result for every mcand ≠ −2^(N−1).
- start while not in IDLE is ignored (no queueing). start in the DONE cycle is also ignored.
- Operand inputs may change freely after acceptance; only the captured values are used.

## Timing
- start sampled high at edge k: INIT in cycle k+1, EVALi in cycle k+2i, SHIFTi in cycle k+2i+1, DONE in cycle k+2N+2 (k+18 at N=8).
- Latency is fixed and independent of operand bits.
- The err path has done at cycle k+2, and product reads 0 from k+2.
- busy=1 for cycles k+1…k+2N+1; busy=0 in DONE and IDLE.
- Reset values: state IDLE, count 0, captured M 0, and all outputs 0 (busy, done, err, reg_load, reg_sel, reg_in). product follows reg_out.
- Reset mid-operation aborts immediately, asynchronously. The controller returns to IDLE and never resumes. The register's own content is the register's responsibility.

## Structure
- Shared package booth_pkg holds:
  - N default;
  - register op codes OP_HOLD=0, OP_LOAD=1, OP_ASR=5;
  - state enum {IDLE, INIT, EVAL, SHIFT, DONE}.
- One natural sub-module: booth_addsub. It is combinational: N-bit A, M, sub → N-bit A±M.
- The rest is a single FSM with a log2(N+1)-bit counter and an N-bit multiplicand register.
- The register itself is instantiated by the parent, not inside this block.

## Test plan
- 3 × 5, start at k → done at k+18, product=16'h000F, err=0. reg_sel trace shows 1, then alternating hold/load and 5, eight times.
- −3 × 5 (8'hFD, 8'h05) → product=16'hFFF1. 127 × −128 (8'h7F, 8'h80) → product=16'hC080 (−16256).
- mcand=8'h80, mplier=8'h02 → done at k+2, err=1, product=0, busy high for exactly one cycle.
- start pulsed again at k+5 during busy → ignored; the first result completes at k+18 unchanged. start in the DONE cycle → no new operation.
- rst driven low at k+9 mid-multiply → all outputs 0 asynchronously and state IDLE. After release, −1 × −1 completes in 18 cycles with product=16'h0001.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier sequencing controller:
// default operand width, register op codes and controller states.
package booth_pkg;

  localparam int N_DEFAULT = 8;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ASR  = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EVAL,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/booth_addsub.sv
// Combinational N-bit wrapping adder/subtractor used for the A +/- M step
// of the Booth iteration; the carry out is intentionally discarded.
module booth_addsub #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] m,
  input  logic         sub,
  output logic [N-1:0] result
);

  assign result = sub ? (a - m) : (a + m);

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for the shared {A, Q, Q-1} shift register of a
// signed Booth multiplier; fixed latency of 2N+2 cycles from start to done.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  input  logic [2*N:0]   reg_out,
  output logic [2*N:0]   reg_in,
  output logic           reg_load,
  output logic [2:0]     reg_sel,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] MCAND_MIN = {1'b1, {(N-1){1'b0}}};

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [N-1:0]  addsub_result;
  logic          mcand_is_min;

  // Negating the most negative multiplicand would overflow N bits, so it is
  // rejected with err instead of producing a wrong product.
  assign mcand_is_min = (mcand_q == MCAND_MIN);
  assign product      = reg_out[2*N:1];

  booth_addsub #(.N(N)) u_addsub (
    .a      (reg_out[2*N:N+1]),
    .m      (mcand_q),
    .sub    (reg_out[1]),
    .result (addsub_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    reg_in   = '0;
    reg_load = 1'b0;
    reg_sel  = OP_HOLD;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = INIT;
          mcand_d  = mcand;
          mplier_d = mplier;
          count_d  = '0;
        end
      end

      INIT: begin
        busy     = 1'b1;
        reg_load = 1'b1;
        reg_sel  = OP_LOAD;
        if (mcand_is_min) begin
          state_d = DONE;
        end else begin
          reg_in  = {{N{1'b0}}, mplier_q, 1'b0};
          state_d = EVAL;
        end
      end

      // Q0/Q-1 = 01 adds M, 10 subtracts M, 00/11 leave the register alone.
      EVAL: begin
        busy = 1'b1;
        if (reg_out[1] ^ reg_out[0]) begin
          reg_load = 1'b1;
          reg_sel  = OP_LOAD;
          reg_in   = {addsub_result, reg_out[N:0]};
        end
        state_d = SHIFT;
      end

      SHIFT: begin
        busy     = 1'b1;
        reg_load = 1'b1;
        reg_sel  = OP_ASR;
        count_d  = count_q + CW'(1);
        state_d  = (count_d == CW'(N)) ? DONE : EVAL;
      end

      DONE: begin
        done    = 1'b1;
        err     = mcand_is_min;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl with a behavioural model of the shared
// {A, Q, Q-1} register; expected products are hand-computed constants.
module tb_booth_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic [16:0] reg_out;
  logic [16:0] reg_in;
  logic        reg_load;
  logic [2:0]  reg_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] product;

  int checks   = 0;
  int failures = 0;

  booth_seq_ctrl #(.N(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .reg_out  (reg_out),
    .reg_in   (reg_in),
    .reg_load (reg_load),
    .reg_sel  (reg_sel),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared shift register model: load on op 1, arithmetic shift on op 5.
  logic [16:0] shreg = '0;
  assign reg_out = shreg;
  always @(posedge clk) begin
    if (reg_load) begin
      if (reg_sel == 3'd1)
        shreg <= reg_in;
      else if (reg_sel == 3'd5)
        shreg <= {shreg[16], shreg[16:1]};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Accept one operation (start sampled at edge k) and follow it cycle by
  // cycle up to the expected done cycle; optionally re-pulse start at
  // cycle k+restartAt while busy.
  task automatic applyStimulus(input string tag, input logic [7:0] mc,
                               input logic [7:0] mp, input logic [15:0] expProd,
                               input logic expErr, input int expLat,
                               input int restartAt);
    int busyCnt  = 0;
    int shiftCnt = 0;
    int earlyDone = 0;
    int selViol  = 0;
    @(negedge clk);
    start  = 1'b1;
    mcand  = mc;
    mplier = mp;
    @(posedge clk);
    for (int cyc = 1; cyc <= expLat; cyc++) begin
      @(negedge clk);
      start  = (cyc == restartAt);
      mcand  = 8'(cyc * 37);
      mplier = 8'(cyc * 91);
      if (busy) busyCnt++;
      if (reg_sel == 3'd5) shiftCnt++;
      if (reg_load !== (reg_sel != 3'd0)) selViol++;
      if (cyc == 1) begin
        if (reg_sel !== 3'd1) selViol++;
      end else if (cyc < expLat) begin
        if ((cyc % 2) == 1) begin
          if (reg_sel !== 3'd5) selViol++;
        end else if (reg_sel !== 3'd0 && reg_sel !== 3'd1) begin
          selViol++;
        end
      end
      if (cyc < expLat && done) earlyDone++;
    end
    start = 1'b0;
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
    checkOutput({tag, "_product"}, 32'(product), 32'(expProd));
    checkOutput({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(expLat - 1));
    checkOutput({tag, "_early_done"}, 32'(earlyDone), 32'd0);
    checkOutput({tag, "_sel_trace"}, 32'(selViol), 32'd0);
    checkOutput({tag, "_shifts"}, 32'(shiftCnt), expErr ? 32'd0 : 32'd8);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_outs", 32'({err, reg_load, reg_sel, reg_in}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("m3x5", 8'h03, 8'h05, 16'h000F, 1'b0, 18, 5);
    // start during DONE must not launch a new operation
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_start_ignored", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("done_start_idle", 32'({busy, done, reg_load}), 32'd0);

    applyStimulus("mn3x5", 8'hFD, 8'h05, 16'hFFF1, 1'b0, 18, 0);
    applyStimulus("m127xn128", 8'h7F, 8'h80, 16'hC080, 1'b0, 18, 0);
    applyStimulus("mn127xn127", 8'h81, 8'h81, 16'h3F01, 1'b0, 18, 0);
    applyStimulus("m0x55", 8'h00, 8'h55, 16'h0000, 1'b0, 18, 0);
    applyStimulus("err_min", 8'h80, 8'h02, 16'h0000, 1'b1, 2, 0);
    @(negedge clk);
    checkOutput("err_after_idle", 32'({busy, done, err}), 32'd0);

    // Asynchronous abort at k+9
    @(negedge clk);
    start  = 1'b1;
    mcand  = 8'h11;
    mplier = 8'h22;
    @(posedge clk);
    repeat (8) @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outs", 32'({busy, done, err, reg_load, reg_sel, reg_in}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_resume", 32'({busy, done, reg_load}), 32'd0);

    applyStimulus("mn1xn1", 8'hFF, 8'hFF, 16'h0001, 1'b0, 18, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
